function_unit_x: RTL and testbench
==================================

FUNCTION_UNIT_X -- requirements
Module: function_unit_x

Interface
REQ-001 SHALL have parameter DATA_W, default 20, the maximum operand width (address-word width); legal values 16..32.
REQ-002 SHALL have parameter MAX_RPT, default 16, the maximum iteration count per operation.
REQ-003 SHALL use one clock; reset is synchronous and active-low.
REQ-004 SHALL have port clk, input, 1: rising-edge clock.
REQ-005 SHALL have port rst_n, input, 1: synchronous active-low reset.
REQ-006 SHALL have port start, input, 1: request an operation; accepted only while busy=0.
REQ-007 SHALL have port fs, input, 5: function select, encoded per package.
REQ-008 SHALL have port size, input, 2: 00 byte (W=8), 01 word (W=16), 10 address (W=DATA_W), 11 reserved and treated as word.
REQ-009 SHALL have port rpt, input, clog2(MAX_RPT): iteration count is rpt+1.
REQ-010 SHALL have ports src and dst, input, DATA_W each: operands.
REQ-011 SHALL have ports zin, vin, nin, cin, input, 1 each: status bits from SR.
REQ-012 SHALL have port busy, output, 1: operation in progress.
REQ-013 SHALL have port done, output, 1: one-cycle pulse; result and flags valid.
REQ-014 SHALL have port result, output, DATA_W: data out.
REQ-015 SHALL have ports zout, vout, nout, cout, output, 1 each: status out.

Function
REQ-016 SHALL use FSM states IDLE and RUN: IDLE->RUN on start; RUN->IDLE when the iteration counter is 0.
REQ-017 SHALL, when start is accepted at edge E0, latch fs, size, src, dst, the flags and count=rpt; busy=1 from E0.
REQ-018 SHALL perform exactly one single-step operation per RUN edge (E1..E(rpt+1)).
REQ-019 SHALL feed back each iteration's result as the next dst and its carry as the next cin; src is held constant.
REQ-020 SHALL, at E(rpt+1), register result and flags, drive done=1 for one cycle and busy=0; latency is rpt+2 edges from start.
REQ-021 SHALL hold result and flags until the next done; start while busy=1 SHALL be ignored with no effect.
REQ-022 SHALL accept start in the cycle done=1, back-to-back.
REQ-023 SHALL zero result bits at and above W; N SHALL be bit W-1; Z SHALL reflect result[W-1:0]==0; carry SHALL be taken out of bit W-1.
REQ-024 SHALL support ops MOV, ADD, ADDC, SUB, SUBC, CMP, DADD, AND, BIT, BIC, BIS, XOR, RRC, RRA, RRU, RLA, SWPB and SXT.
REQ-025 SHALL use MSP430 flag rules for each op: SUBC = dst+~src+cin; AND/BIT/XOR set C=~Z; V=0 on AND/BIT/rotates/SXT; XOR sets V=src[W-1]&dst[W-1]; MOV/BIC/BIS/SWPB leave the flags unchanged.
REQ-026 SHALL compute RRU as a logical shift right with MSB=0 and C=LSB; RLA as dst+dst.
REQ-027 SHALL compute DADD as BCD over W/4 digits with a +6 correction per digit, ripple carry in from cin, and V=0.
REQ-028 SHALL apply SWPB to the low 16 bits only; SXT SHALL extend bit 7 to W bits.
REQ-029 SHALL compute CMP and BIT identically to SUB and AND; the caller suppresses writeback.
REQ-030 SHALL, for an undefined fs, return 16'hDEAD masked to W with flags unchanged, and still pulse done.

Reset
REQ-031 SHALL, on rst_n=0 at any edge including mid-RUN, go to IDLE and drive busy=0, done=0, result=0 and all flag outputs 0, aborting the operation.

Structure
REQ-032 SHALL define the fs encodings, size encodings, the 16'hDEAD constant and the FSM state encodings in the shared package fu_x_pkg.
REQ-033 SHALL implement the single-step combinational datapath as sub-module fu_step, parametrised by DATA_W; function_unit_x holds the FSM, counter and feedback registers.

Verification
REQ-034 SHALL cover: ADD, word, src=0x7FFF, dst=0x0001, rpt=0 -> result=0x8000, N=1, V=1, Z=0, C=0; done 2 edges after start.
REQ-035 SHALL cover: RRC, byte, dst=0x81, cin=0, rpt=3 -> result=0x28, C=0, N=0, Z=0, V=0; done at edge 5; busy high for 4 cycles.
REQ-036 SHALL cover: ADDC, address, DATA_W=20, src=0xFFFFF, dst=0x00001, cin=0 -> result=0x00000, C=1, Z=1, N=0, V=0.
REQ-037 SHALL cover: DADD, word, 0x0999+0x0001 -> 0x1000, C=0; 0x9999+0x0001 -> 0x0000, C=1, Z=1.
REQ-038 SHALL cover: start with rpt=15, second start at E3 -> ignored; rst_n=0 at E5 -> busy=0, done=0, result=0 and flags 0 after E5; no done pulse.
REQ-039 SHALL cover: undefined fs, word, zin/vin/nin/cin=1/0/1/0 -> result=0xDEAD, flags 1/0/1/0, done pulse.

Source files
------------

// File: rtl/fu_x_pkg.sv
// fu_x_pkg: shared encodings and helpers for function_unit_x
package fu_x_pkg;
  typedef enum logic [4:0] {
    FS_MOV  = 5'd0,
    FS_ADD  = 5'd1,
    FS_ADDC = 5'd2,
    FS_SUB  = 5'd3,
    FS_SUBC = 5'd4,
    FS_CMP  = 5'd5,
    FS_DADD = 5'd6,
    FS_AND  = 5'd7,
    FS_BIT  = 5'd8,
    FS_BIC  = 5'd9,
    FS_BIS  = 5'd10,
    FS_XOR  = 5'd11,
    FS_RRC  = 5'd12,
    FS_RRA  = 5'd13,
    FS_RRU  = 5'd14,
    FS_RLA  = 5'd15,
    FS_SWPB = 5'd16,
    FS_SXT  = 5'd17
  } fs_e;
  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_WORD = 2'b01,
    SZ_ADDR = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;
  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;
  localparam logic [15:0] UNDEF_VAL = 16'hDEAD;
  // active operand width; the reserved size code behaves as a word
  function automatic int unsigned op_width(input logic [1:0] size, input int unsigned data_w);
    return size == SZ_BYTE ? 32'd8 : size == SZ_ADDR ? data_w : 32'd16;
  endfunction
endpackage

// File: rtl/fu_x_step.sv
// fu_step: one combinational iteration of the function unit at the selected width
module fu_step
  import fu_x_pkg::*;
#(
  parameter int DATA_W = 20
) (
  input  logic [4:0]        fs_i,
  input  logic [1:0]        size_i,
  input  logic [DATA_W-1:0] src_i,
  input  logic [DATA_W-1:0] dst_i,
  input  logic              z_i,
  input  logic              v_i,
  input  logic              n_i,
  input  logic              c_i,
  output logic [DATA_W-1:0] res_o,
  output logic              z_o,
  output logic              v_o,
  output logic              n_o,
  output logic              c_o
);
  logic [DATA_W-1:0] mask, top, s, d, b, r, bcd;
  logic [DATA_W:0] sum;
  logic [4:0] dig;
  logic ci, ac, av, bc, cy, ov, keep;
  // operands masked to the active width; top is a one-hot of bit W-1
  always_comb begin
    mask = ~({DATA_W{1'b1}} << op_width(size_i, DATA_W));
    top = mask & ~(mask >> 1);
    s = src_i & mask;
    d = dst_i & mask;
  end
  // shared adder: subtraction adds the inverted source, RLA adds dst to itself
  always_comb begin
    b = fs_i == FS_RLA ? d : (fs_i == FS_SUB || fs_i == FS_SUBC || fs_i == FS_CMP) ? ~s & mask : s;
    ci = (fs_i == FS_ADDC || fs_i == FS_SUBC) ? c_i : (fs_i == FS_SUB || fs_i == FS_CMP);
    sum = {1'b0, d} + {1'b0, b} + {{DATA_W{1'b0}}, ci};
    ac = |(sum & {top, 1'b0});
    av = ((|(d & top)) == (|(b & top))) && ((|(sum[DATA_W-1:0] & top)) != (|(d & top)));
  end
  // decimal add, one nibble at a time with +6 correction and rippling carry
  always_comb begin
    bcd = '0;
    bc = c_i;
    dig = '0;
    for (int k = 0; k < DATA_W / 4; k++) begin
      if (k < op_width(size_i, DATA_W) / 4) begin
        dig = {1'b0, d[4*k +: 4]} + {1'b0, s[4*k +: 4]} + {4'd0, bc};
        bc = dig > 5'd9;
        bcd[4*k +: 4] = bc ? dig[3:0] + 4'd6 : dig[3:0];
      end
    end
  end
  // per-op result and flags; keep passes the incoming status through untouched
  always_comb begin
    r = d;
    cy = c_i;
    ov = 1'b0;
    keep = 1'b0;
    case (fs_i)
      FS_MOV: begin
        r = s;
        keep = 1'b1;
      end
      FS_ADD, FS_ADDC, FS_SUB, FS_SUBC, FS_CMP, FS_RLA: begin
        r = sum[DATA_W-1:0];
        cy = ac;
        ov = av;
      end
      FS_DADD: begin
        r = bcd;
        cy = bc;
      end
      FS_AND, FS_BIT: begin
        r = d & s;
        cy = |(d & s);
      end
      FS_XOR: begin
        r = d ^ s;
        cy = |(d ^ s);
        ov = |(d & s & top);
      end
      FS_BIC: begin
        r = d & ~s;
        keep = 1'b1;
      end
      FS_BIS: begin
        r = d | s;
        keep = 1'b1;
      end
      FS_RRC: begin
        r = (d >> 1) | (c_i ? top : '0);
        cy = d[0];
      end
      FS_RRA: begin
        r = (d >> 1) | (d & top);
        cy = d[0];
      end
      FS_RRU: begin
        r = d >> 1;
        cy = d[0];
      end
      FS_SWPB: begin
        r = d;
        r[15:0] = {d[7:0], d[15:8]};
        keep = 1'b1;
      end
      FS_SXT: begin
        r = {{(DATA_W-8){d[7]}}, d[7:0]};
        cy = |d[7:0];
      end
      default: begin
        r = DATA_W'(UNDEF_VAL);
        keep = 1'b1;
      end
    endcase
    res_o = r & mask;
    z_o = keep ? z_i : ~|res_o;
    n_o = keep ? n_i : |(res_o & top);
    c_o = keep ? c_i : cy;
    v_o = keep ? v_i : ov;
  end
endmodule

// File: rtl/function_unit_x.sv
// function_unit_x: iterating ALU; runs fu_step rpt+1 times with result/carry feedback
module function_unit_x
  import fu_x_pkg::*;
#(
  parameter int DATA_W  = 20,
  parameter int MAX_RPT = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [4:0]                 fs,
  input  logic [1:0]                 size,
  input  logic [$clog2(MAX_RPT)-1:0] rpt,
  input  logic [DATA_W-1:0]          src,
  input  logic [DATA_W-1:0]          dst,
  input  logic                       zin,
  input  logic                       vin,
  input  logic                       nin,
  input  logic                       cin,
  output logic                       busy,
  output logic                       done,
  output logic [DATA_W-1:0]          result,
  output logic                       zout,
  output logic                       vout,
  output logic                       nout,
  output logic                       cout
);
  localparam int RW = $clog2(MAX_RPT);
  state_e state_q;
  logic [4:0] fs_q;
  logic [1:0] size_q;
  logic [RW-1:0] cnt_q;
  logic [DATA_W-1:0] src_q, dst_q, res_q, dst_d;
  logic z_q, v_q, n_q, c_q, z_d, v_d, n_d, c_d;
  logic zo_q, vo_q, no_q, co_q, done_q;
  fu_step #(.DATA_W(DATA_W)) u_step (
    .fs_i  (fs_q),
    .size_i(size_q),
    .src_i (src_q),
    .dst_i (dst_q),
    .z_i   (z_q),
    .v_i   (v_q),
    .n_i   (n_q),
    .c_i   (c_q),
    .res_o (dst_d),
    .z_o   (z_d),
    .v_o   (v_d),
    .n_o   (n_d),
    .c_o   (c_d)
  );
  // sequencer: latch on accepted start, feed each step back, publish on the last step
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      fs_q <= '0;
      size_q <= '0;
      cnt_q <= '0;
      src_q <= '0;
      dst_q <= '0;
      {z_q, v_q, n_q, c_q} <= '0;
      res_q <= '0;
      {zo_q, vo_q, no_q, co_q} <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (start) begin
          state_q <= S_RUN;
          fs_q <= fs;
          size_q <= size;
          cnt_q <= rpt;
          src_q <= src;
          dst_q <= dst;
          {z_q, v_q, n_q, c_q} <= {zin, vin, nin, cin};
        end
        S_RUN: begin
          dst_q <= dst_d;
          {z_q, v_q, n_q, c_q} <= {z_d, v_d, n_d, c_d};
          if (cnt_q == '0) begin
            state_q <= S_IDLE;
            done_q <= 1'b1;
            res_q <= dst_d;
            {zo_q, vo_q, no_q, co_q} <= {z_d, v_d, n_d, c_d};
          end else cnt_q <= cnt_q - 1'b1;
        end
      endcase
    end
  end
  assign busy = state_q == S_RUN;
  assign done = done_q;
  assign result = res_q;
  assign {zout, vout, nout, cout} = {zo_q, vo_q, no_q, co_q};
endmodule

// File: tb/tb_function_unit_x.sv
// tb_function_unit_x: directed and randomized checks against a behavioural model
module tb_function_unit_x;
  import fu_x_pkg::*;
  localparam int DW = 20;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [4:0] fs = '0;
  logic [1:0] size = '0;
  logic [3:0] rpt = '0;
  logic [DW-1:0] src = '0, dst = '0;
  logic zin = 1'b0, vin = 1'b0, nin = 1'b0, cin = 1'b0;
  logic busy, done, zout, vout, nout, cout;
  logic [DW-1:0] result;
  int errs = 0, checks = 0;
  bit armed = 1'b0;
  bit m_busy = 1'b0, m_done = 1'b0;
  int m_left = 0;
  longint unsigned m_res = 0, p_res = 0;
  logic [3:0] m_fl = '0, p_fl = '0;

  always #5 clk = ~clk;

  function_unit_x #(.DATA_W(DW), .MAX_RPT(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .fs(fs), .size(size), .rpt(rpt),
    .src(src), .dst(dst), .zin(zin), .vin(vin), .nin(nin), .cin(cin),
    .busy(busy), .done(done), .result(result),
    .zout(zout), .vout(vout), .nout(nout), .cout(cout)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic longint sgn(input longint unsigned x, input longint unsigned h);
    return x >= h ? longint'(x) - 2 * longint'(h) : longint'(x);
  endfunction

  // whole operation at integer level: rpt+1 steps, result and carry fed back
  function automatic void model_op(input int f, input int sz, input int r,
                                   input longint unsigned s0, input longint unsigned d0,
                                   input logic [3:0] fl,
                                   output longint unsigned res, output logic [3:0] flo);
    int w;
    longint unsigned m, h, s, x, a, t, lo, y, dg;
    longint sv;
    bit z, v, n, c, ci, dc, nb, upd;
    w = (sz == 0) ? 8 : (sz == 2) ? DW : 16;
    m = 64'd1 << w;
    h = m >> 1;
    s = s0 % m;
    x = d0 % m;
    {z, v, n, c} = fl;
    for (int i = 0; i <= r; i++) begin
      upd = 1'b1;
      case (f)
        FS_MOV: begin x = s; upd = 1'b0; end
        FS_ADD, FS_ADDC, FS_RLA: begin
          a = (f == FS_RLA) ? x : s;
          ci = (f == FS_ADDC) ? c : 1'b0;
          t = x + a + longint'(ci);
          sv = sgn(x, h) + sgn(a, h) + longint'(ci);
          x = t % m;
          c = t >= m;
          v = sv < -longint'(h) || sv >= longint'(h);
        end
        FS_SUB, FS_SUBC, FS_CMP: begin
          ci = (f == FS_SUBC) ? c : 1'b1;
          t = x + (m - 1 - s) + longint'(ci);
          sv = sgn(x, h) - sgn(s, h) - 1 + longint'(ci);
          x = t % m;
          c = t >= m;
          v = sv < -longint'(h) || sv >= longint'(h);
        end
        FS_DADD: begin
          dc = c;
          y = 0;
          for (int k = 0; k < w / 4; k++) begin
            dg = ((x >> (4 * k)) & 15) + ((s >> (4 * k)) & 15) + longint'(dc);
            dc = dg > 9;
            if (dc) dg = (dg + 6) & 15;
            y += dg << (4 * k);
          end
          x = y;
          c = dc;
          v = 1'b0;
        end
        FS_AND, FS_BIT: begin x = x & s; c = x != 0; v = 1'b0; end
        FS_XOR: begin v = (x >= h) && (s >= h); x = x ^ s; c = x != 0; end
        FS_BIC: begin x = x & ~s; upd = 1'b0; end
        FS_BIS: begin x = x | s; upd = 1'b0; end
        FS_RRC: begin nb = c; c = x[0]; x = x / 2 + (nb ? h : 0); v = 1'b0; end
        FS_RRA: begin nb = x >= h; c = x[0]; x = x / 2 + (nb ? h : 0); v = 1'b0; end
        FS_RRU: begin c = x[0]; x = x / 2; v = 1'b0; end
        FS_SWPB: begin
          lo = x % 65536;
          x = ((x - lo) + (lo % 256) * 256 + lo / 256) % m;
          upd = 1'b0;
        end
        FS_SXT: begin
          lo = x % 256;
          x = (lo >= 128) ? (m - 256 + lo) : lo;
          c = x != 0;
          v = 1'b0;
        end
        default: begin x = 64'hDEAD % m; upd = 1'b0; end
      endcase
      if (upd) begin
        n = x >= h;
        z = x == 0;
      end
    end
    res = x;
    flo = {z, v, n, c};
  endfunction

  // reference timing: accept when idle, done rpt+1 edges later
  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_done = 1'b0; m_res = 0; m_fl = '0; m_left = 0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 1'b0; m_done = 1'b1; m_res = p_res; m_fl = p_fl;
        end
      end else if (start) begin
        model_op(fs, size, rpt, src, dst, {zin, vin, nin, cin}, p_res, p_fl);
        m_left = rpt + 1;
        m_busy = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("result", result, m_res);
      chk("flags", {zout, vout, nout, cout}, m_fl);
    end
  end

  task automatic run_op(input logic [4:0] f, input logic [1:0] sz, input logic [3:0] r,
                        input logic [DW-1:0] s, input logic [DW-1:0] d, input logic [3:0] fl,
                        output int edges, output int bcyc);
    fs = f; size = sz; rpt = r; src = s; dst = d; {zin, vin, nin, cin} = fl; start = 1'b1;
    edges = 0;
    bcyc = 0;
    @(posedge clk);
    edges++;
    @(negedge clk);
    start = 1'b0;
    if (busy) bcyc++;
    while (!done && edges < 40) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (busy) bcyc++;
    end
    chk("done_seen", done, 1);
  endtask

  task automatic chk_out(input string nm, input logic [63:0] er, input logic [3:0] ef);
    chk({nm, "_res"}, result, er);
    chk({nm, "_res_model"}, m_res, er);
    chk({nm, "_flags"}, {zout, vout, nout, cout}, ef);
    chk({nm, "_flags_model"}, m_fl, ef);
  endtask

  initial begin
    int e, bc;
    repeat (2) @(posedge clk);
    @(negedge clk);
    armed = 1'b1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", {zout, vout, nout, cout}, 0);
    rst_n = 1'b1;
    run_op(FS_ADD, SZ_WORD, 4'd0, 'h7FFF, 'h0001, 4'b0000, e, bc);
    chk_out("add", 'h8000, 4'b0110);
    chk("add_latency", e, 2);
    run_op(FS_RRC, SZ_BYTE, 4'd3, 'h0, 'h81, 4'b0000, e, bc);
    chk_out("rrc", 'h28, 4'b0000);
    chk("rrc_latency", e, 5);
    chk("rrc_busy_cycles", bc, 4);
    run_op(FS_ADDC, SZ_ADDR, 4'd0, 'hFFFFF, 'h00001, 4'b0000, e, bc);
    chk_out("addc", 'h0, 4'b1001);
    run_op(FS_DADD, SZ_WORD, 4'd0, 'h0001, 'h0999, 4'b0000, e, bc);
    chk_out("dadd1", 'h1000, 4'b0000);
    run_op(FS_DADD, SZ_WORD, 4'd0, 'h0001, 'h9999, 4'b0000, e, bc);
    chk_out("dadd2", 'h0, 4'b1001);
    run_op(5'd31, SZ_WORD, 4'd0, 'h1234, 'h5678, 4'b1010, e, bc);
    chk_out("undef", 'hDEAD, 4'b1010);
    run_op(5'd20, SZ_BYTE, 4'd0, 'h1234, 'h5678, 4'b0101, e, bc);
    chk_out("undef_byte", 'hAD, 4'b0101);
    run_op(FS_SXT, SZ_WORD, 4'd0, 'h0, 'h0080, 4'b0000, e, bc);
    chk_out("sxt", 'hFF80, 4'b0011);
    fs = FS_ADD; size = SZ_WORD; rpt = 4'd15; src = 'h1; dst = 'h1;
    {zin, vin, nin, cin} = 4'b0000;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1; fs = FS_MOV; rpt = 4'd0; src = 'h3;
    @(negedge clk);
    start = 1'b0;
    chk("ignored_busy", busy, 1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_result", result, 0);
    chk("abort_flags", {zout, vout, nout, cout}, 0);
    repeat (20) begin
      @(negedge clk);
      chk("abort_no_done", done, 0);
    end
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst_n = $urandom_range(0, 299) != 0;
      start = $urandom_range(0, 2) != 0;
      fs = 5'($urandom_range(0, 23));
      size = 2'($urandom_range(0, 3));
      rpt = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 2));
      src = DW'($urandom);
      dst = DW'($urandom);
      {zin, vin, nin, cin} = 4'($urandom);
      if ($urandom_range(0, 3) == 0) src = ($urandom_range(0, 1) == 0) ? DW'('h7FFF) : '1;
      if ($urandom_range(0, 3) == 0) dst = ($urandom_range(0, 1) == 0) ? DW'('h80) : '0;
    end
    @(negedge clk);
    armed = 1'b0;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
